// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// A fetch entry pairs an instruction word with the byte address it came from.
package fetch_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [WORD_SIZE-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: registered storage, simultaneous push/pop, synchronous flush.
// dout always shows the head slot; the caller qualifies it with count != 0.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count < FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory,
// buffers {pc, instr} pairs and hands them to decode over valid/ready.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [WORD_SIZE-1:0] LAST_PC = WORD_SIZE'(MEM_BYTES - INSTR_BYTES);

    fetch_state_t         r_state;
    fetch_state_t         w_next_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic                 r_halted;
    logic                 r_fault;
    logic [31:0]          r_fetch_count;

    logic [CNT_W-1:0]     w_count;
    fetch_entry_t         w_head;
    fetch_entry_t         w_entry;
    logic                 w_pop;
    logic                 w_redirect;
    logic                 w_misaligned;
    logic                 w_in_bounds;
    logic                 w_push;

    assign w_pop        = out_valid && out_ready;
    assign w_redirect   = redirect_valid && ((r_state == RUN) || (r_state == HALT));
    assign w_misaligned = !is_word_aligned(redirect_pc);
    assign w_in_bounds  = (r_pc <= LAST_PC);
    // A redirect cancels this cycle's fetch; the bounds check also catches PC wrap.
    assign w_push       = (r_state == RUN) && !w_redirect && w_in_bounds &&
                          ((w_count < FULL) || w_pop);
    assign w_entry      = '{pc: r_pc, instr: imem_instr};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_redirect),
        .push  (w_push),
        .din   (w_entry),
        .pop   (w_pop && !w_redirect),
        .dout  (w_head),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next_state = RUN;
            end
            RUN: begin
                if (w_redirect)        w_next_state = w_misaligned ? FAULT : RUN;
                else if (!w_in_bounds) w_next_state = HALT;
            end
            HALT: begin
                if (w_redirect) w_next_state = w_misaligned ? FAULT : RUN;
            end
            FAULT: w_next_state = FAULT;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if ((r_state == IDLE) && start) r_pc <= RESET_PC;
            else if (w_redirect)            r_pc <= redirect_pc;
            else if (w_push)                r_pc <= r_pc + WORD_SIZE'(INSTR_BYTES);

            if (w_push) r_fetch_count <= r_fetch_count + 32'd1;

            if (w_redirect && w_misaligned) r_fault <= 1'b1;

            if (w_redirect && !w_misaligned)                     r_halted <= 1'b0;
            else if ((r_state == RUN) && !w_redirect && !w_in_bounds) r_halted <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign out_valid   = (w_count != '0);
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized run, all
// compared cycle by cycle against a queue-based model of the fetch rules.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          MEMB     = 1024;
    localparam int          DEPTH    = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          m_state;
    logic [31:0] m_pc;
    ent_t        q[$];
    logic        m_halted;
    logic        m_fault;
    logic [31:0] m_cnt;

    logic [131:0] dut_snap;

    instr_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .MEM_BYTES  (MEMB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb imem_instr = (imem_addr < 32'(MEMB)) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

    assign dut_snap = {out_valid, out_valid ? out_pc : 32'h0, out_valid ? out_instr : 32'h0,
                       busy, halted, fault, fetch_count, imem_addr};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'(MEMB)) ? mem[a[9:2]] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [131:0] exp_snap();
        ent_t h;
        logic v;
        v = (q.size() != 0);
        h = '0;
        if (v) h = q[0];
        return {v, h.pc, h.instr, (m_state == S_RUN), m_halted, m_fault, m_cnt, m_pc};
    endfunction

    task automatic model_step();
        int  sz;
        bit  pop;
        bit  redir;
        if (rst) begin
            m_state = S_IDLE; m_pc = RESET_PC; q.delete();
            m_halted = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
            return;
        end
        sz    = q.size();
        pop   = (sz != 0) && out_ready;
        redir = redirect_valid && (m_state == S_RUN || m_state == S_HALT);
        if (m_state == S_IDLE) begin
            if (start) begin m_state = S_RUN; m_pc = RESET_PC; end
        end else if (redir) begin
            q.delete();
            m_pc = redirect_pc;
            if (redirect_pc % 4 != 0) begin m_state = S_FAULT; m_fault = 1'b1; end
            else begin m_state = S_RUN; m_halted = 1'b0; end
        end else begin
            if (pop) void'(q.pop_front());
            if (m_state == S_RUN) begin
                if (m_pc > 32'(MEMB - 4)) begin
                    m_state = S_HALT; m_halted = 1'b1;
                end else if (sz < DEPTH || pop) begin
                    q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick();
        n_checks++;
        if (dut_snap !== exp_snap()) begin
            n_errors++; $display("FAIL reset_snap: got %h expected %h", dut_snap, exp_snap());
        end
        n_checks++;
        if ({out_valid, out_pc, out_instr, fetch_count} !== 97'h0) begin
            n_errors++;
            $display("FAIL reset_outs: got v=%b pc=%h instr=%h cnt=%0d expected all zero",
                     out_valid, out_pc, out_instr, fetch_count);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, fetch_count} !== {1'b1, 32'h0, 32'h2008_0005, 32'd1}) begin
            n_errors++;
            $display("FAIL basic_first: got v=%b pc=%h instr=%h cnt=%0d expected 1/0/20080005/1",
                     out_valid, out_pc, out_instr, fetch_count);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, fetch_count} !== {1'b1, 32'h4, 32'h2109_0003, 32'd2}) begin
            n_errors++;
            $display("FAIL basic_second: got v=%b pc=%h instr=%h cnt=%0d expected 1/4/21090003/2",
                     out_valid, out_pc, out_instr, fetch_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_snap !== exp_snap()) begin
                n_errors++; $display("FAIL basic_cyc%0d: got %h expected %h", i, dut_snap, exp_snap());
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if ({imem_addr, fetch_count, out_valid, out_pc} !== {32'h8, 32'd2, 1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL stall_hold: got addr=%h cnt=%0d v=%b pc=%h expected 8/2/1/0",
                     imem_addr, fetch_count, out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && out_ready) got.push_back(out_pc);
            tick();
            n_checks++;
            if (dut_snap !== exp_snap()) begin
                n_errors++; $display("FAIL stall_cyc%0d: got %h expected %h", i, dut_snap, exp_snap());
            end
        end
        n_checks++;
        if (got.size() < 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
            n_errors++;
            $display("FAIL stall_order: got %0d entries first=%h,%h,%h expected 0,4,8", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx,
                     (got.size() > 2) ? got[2] : 32'hx);
        end
    endtask

    task automatic test_redirect();
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        n_checks++;
        if (dut_snap !== exp_snap() || out_pc !== 32'h8 || fetch_count !== 32'd4) begin
            n_errors++; $display("FAIL redir_pre: got %h pc=%h expected %h pc=8", dut_snap, out_pc, exp_snap());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40; tick(); idle_inputs();
        n_checks++;
        if ({out_valid, fetch_count, imem_addr} !== {1'b0, 32'd4, 32'h40}) begin
            n_errors++;
            $display("FAIL redir_flush: got v=%b cnt=%0d addr=%h expected 0/4/40", out_valid, fetch_count, imem_addr);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, fetch_count} !== {1'b1, 32'h40, mem[16], 32'd5}) begin
            n_errors++;
            $display("FAIL redir_target: got v=%b pc=%h instr=%h cnt=%0d expected 1/40/%h/5",
                     out_valid, out_pc, out_instr, fetch_count, mem[16]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] got[$];
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3FC; tick(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid && out_ready) got.push_back(out_pc);
            n_checks++;
            if (dut_snap !== exp_snap()) begin
                n_errors++; $display("FAIL halt_cyc%0d: got %h expected %h", i, dut_snap, exp_snap());
            end
        end
        n_checks++;
        if (got.size() != 1 || got[0] !== 32'h3FC || {halted, busy, imem_addr} !== {1'b1, 1'b0, 32'h400}) begin
            n_errors++;
            $display("FAIL halt_state: got n=%0d halted=%b busy=%b addr=%h expected 1 word@3fc, 1/0/400",
                     got.size(), halted, busy, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0; tick(); idle_inputs();
        n_checks++;
        if ({halted, busy, out_valid} !== 3'b010) begin
            n_errors++; $display("FAIL halt_resume: got halted=%b busy=%b v=%b expected 0/1/0", halted, busy, out_valid);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h2008_0005}) begin
            n_errors++; $display("FAIL halt_refetch: got v=%b pc=%h instr=%h expected 1/0/20080005", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_fault();
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h42; tick(); idle_inputs();
        n_checks++;
        if ({fault, out_valid, busy} !== 3'b100) begin
            n_errors++; $display("FAIL fault_enter: got fault=%b v=%b busy=%b expected 1/0/0", fault, out_valid, busy);
        end
        for (int i = 0; i < 6; i++) begin
            start = i[0]; redirect_valid = ~i[0]; redirect_pc = 32'h10;
            tick();
            n_checks++;
            if (dut_snap !== exp_snap() || {fault, out_valid, busy} !== 3'b100) begin
                n_errors++; $display("FAIL fault_stuck%0d: got %h expected %h", i, dut_snap, exp_snap());
            end
        end
        idle_inputs();
        rst = 1'b1; tick(); idle_inputs();
        n_checks++;
        if ({fault, halted, busy, out_valid, fetch_count, imem_addr} !== {4'b0000, 32'd0, RESET_PC}) begin
            n_errors++; $display("FAIL fault_clear: got fault=%b halted=%b busy=%b v=%b cnt=%0d addr=%h expected zeros",
                                 fault, halted, busy, out_valid, fetch_count, imem_addr);
        end
    endtask

    task automatic test_start_redirect();
        rst = 1'b1; tick(); idle_inputs();
        out_ready = 1'b1;
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; tick(); idle_inputs();
        tick();
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, RESET_PC}) begin
            n_errors++; $display("FAIL start_wins: got v=%b pc=%h expected 1/%h", out_valid, out_pc, RESET_PC);
        end
        out_ready = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (dut_snap !== exp_snap()) begin
            n_errors++; $display("FAIL full_before_rst: got %h expected %h", dut_snap, exp_snap());
        end
        rst = 1'b1; tick(); idle_inputs();
        n_checks++;
        if ({out_valid, fetch_count, busy} !== {1'b0, 32'd0, 1'b0}) begin
            n_errors++; $display("FAIL midrun_rst: got v=%b cnt=%0d busy=%b expected 0/0/0", out_valid, fetch_count, busy);
        end
    endtask

    task automatic test_random();
        int r;
        rst = 1'b1; tick(); idle_inputs();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            out_ready      = ($urandom_range(0, 3) != 0);
            start          = (r < 8);
            rst            = (r >= 86 && r < 89);
            redirect_valid = (r >= 90);
            case ($urandom_range(0, 4))
                0:       redirect_pc = 32'($urandom_range(0, 255)) * 32'd4;
                1:       redirect_pc = 32'h3F0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       redirect_pc = 32'h1000;
                3:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = $urandom | 32'h1;
            endcase
            tick();
            n_checks++;
            if (dut_snap !== exp_snap()) begin
                n_errors++; $display("FAIL random_cyc%0d: got %h expected %h", i, dut_snap, exp_snap());
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2109_0003;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_start_redirect();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
